// File: rtl/dfi_sched_pkg.sv
// -----------------------------------------------------------------------------
// dfi_sched_pkg
// Shared types and constants for the per-channel DFI command scheduler.
//   - DRAM timing defaults used by every channel instance
//   - DFI command encodes {cmd1,cmd0}
//   - scheduler FSM state enum
//   - latched request record {write, bank, page, col}
// The request record is sized by DFI_BANK_W / DFI_ADDR_W, so these are the
// upper bounds for the scheduler's BANK_W / ADDR_W parameters.
// -----------------------------------------------------------------------------
package dfi_sched_pkg;

    // Channel address geometry.
    localparam int DFI_BANK_W     = 5;
    localparam int DFI_ADDR_W     = 13;

    // DRAM timing defaults shared by all channel instances.
    localparam int DEF_T_RP       = 2;
    localparam int DEF_T_RCD      = 2;
    localparam int DEF_BURST_SIZE = 2;

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_PRE = 2'b01,
        CMD_RD  = 2'b10,
        CMD_WR  = 2'b11
    } dfi_cmd_e;

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_ARB,
        ST_PRE,
        ST_PRE_WAIT,
        ST_ACT,
        ST_ACT_WAIT,
        ST_ACCESS
    } sched_state_e;

    typedef struct packed {
        logic                  write;
        logic [DFI_BANK_W-1:0] bank;
        logic [DFI_ADDR_W-1:0] page;
        logic [DFI_ADDR_W-1:0] col;
    } sched_req_t;

endpackage

// File: rtl/dfi_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// dfi_sched_rr_arb
// Combinational round-robin picker: grants the first asserted valid found
// searching upward from ptr, wrapping at NUM_REQ.
// Ports:
//   valid  in   NUM_REQ  request lines
//   ptr    in   IDX_W    highest-priority index this cycle
//   grant  out  NUM_REQ  one-hot grant (all zero when nothing valid)
//   idx    out  IDX_W    binary index of the grant
//   any    out  1        some request was granted
// -----------------------------------------------------------------------------
module dfi_sched_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // Walk offsets from farthest to nearest so the nearest valid one,
        // written last, wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (valid[cand]) begin
                grant = NUM_REQ'(1) << cand;
                idx   = IDX_W'(cand);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dfi_cmd_sched.sv
// -----------------------------------------------------------------------------
// dfi_cmd_sched
// Per-channel DRAM command scheduler: round-robin arbitration over NUM_REQ
// requesters, open-page tracking per bank, PRE/ACT/RD/WR sequencing under
// T_RP / T_RCD / burst occupancy, and write-data beat pacing.
// Ports:
//   clk                  in   scheduler clock
//   reset_poweron_n      in   async active-low reset
//   dfi__mmc__init_done  in   DFI init complete; low forces WAIT_INIT
//   req__sched__valid    in   per-requester valid
//   req__sched__write    in   per-requester 1 = write
//   req__sched__bank     in   packed per-requester bank
//   req__sched__page     in   packed per-requester page
//   req__sched__col      in   packed per-requester column
//   sched__req__ready    out  one-hot accept pulse, same cycle as RD/WR
//   sched__dfi__cs       out  command valid
//   sched__dfi__cmd1/0   out  command encode
//   sched__dfi__bank     out  command bank
//   sched__dfi__addr     out  page (ACT) or column (RD/WR)
//   sched__wdata__pop    out  write-data beat request
//   sched__idle          out  nothing latched, no burst in flight
// All outputs are registered and loaded on the edge that enters the state
// owning the command, so PRE and ACT are on the bus during the PRE / ACT
// state cycles and a page hit reaches the bus one cycle after arbitration.
// -----------------------------------------------------------------------------
module dfi_cmd_sched
    import dfi_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_BANKS  = 32,
    parameter int BANK_W     = DFI_BANK_W,
    parameter int ADDR_W     = DFI_ADDR_W,
    parameter int T_RP       = DEF_T_RP,
    parameter int T_RCD      = DEF_T_RCD,
    parameter int BURST_SIZE = DEF_BURST_SIZE
) (
    input  logic                      clk,
    input  logic                      reset_poweron_n,
    input  logic                      dfi__mmc__init_done,
    input  logic [NUM_REQ-1:0]        req__sched__valid,
    input  logic [NUM_REQ-1:0]        req__sched__write,
    input  logic [NUM_REQ*BANK_W-1:0] req__sched__bank,
    input  logic [NUM_REQ*ADDR_W-1:0] req__sched__page,
    input  logic [NUM_REQ*ADDR_W-1:0] req__sched__col,
    output logic [NUM_REQ-1:0]        sched__req__ready,
    output logic                      sched__dfi__cs,
    output logic                      sched__dfi__cmd1,
    output logic                      sched__dfi__cmd0,
    output logic [BANK_W-1:0]         sched__dfi__bank,
    output logic [ADDR_W-1:0]         sched__dfi__addr,
    output logic                      sched__wdata__pop,
    output logic                      sched__idle
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (T_RP > T_RCD) ? ((T_RP > BURST_SIZE) ? T_RP : BURST_SIZE)
                                            : ((T_RCD > BURST_SIZE) ? T_RCD : BURST_SIZE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_e        state_q, state_d;
    sched_req_t          req_q, req_d, arb_req;
    logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0]    burst_q, burst_d;
    logic                burst_wr_q, burst_wr_d;

    logic                cs_q, cs_d;
    dfi_cmd_e            cmd_q, cmd_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                pop_q, pop_d;
    logic                idle_q, idle_d;

    logic [NUM_BANKS-1:0] open_valid_q;
    logic [ADDR_W-1:0]    open_page_q [NUM_BANKS];
    logic                 pt_set, pt_clr, pt_clr_all;
    logic [BANK_W-1:0]    pt_bank;
    logic [ADDR_W-1:0]    pt_page;

    logic [NUM_REQ-1:0]  arb_valid, arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                issue_pre, issue_act, try_access;

    // A requester still shows valid in the cycle its ready is on the wire;
    // hide it for that cycle so the same request is not granted twice.
    assign arb_valid = req__sched__valid & ~ready_q;

    dfi_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .valid (arb_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        arb_req       = '0;
        arb_req.write = req__sched__write[arb_idx];
        arb_req.bank  = DFI_BANK_W'(req__sched__bank[int'(arb_idx) * BANK_W +: BANK_W]);
        arb_req.page  = DFI_ADDR_W'(req__sched__page[int'(arb_idx) * ADDR_W +: ADDR_W]);
        arb_req.col   = DFI_ADDR_W'(req__sched__col[int'(arb_idx) * ADDR_W +: ADDR_W]);
    end

    assign pt_bank = BANK_W'(req_d.bank);
    assign pt_page = ADDR_W'(req_d.page);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        wait_d      = wait_q;
        burst_d     = (burst_q != '0) ? burst_q - CNT_W'(1) : '0;
        burst_wr_d  = burst_wr_q;
        cs_d        = 1'b0;
        cmd_d       = CMD_ACT;
        bank_d      = '0;
        addr_d      = '0;
        ready_d     = '0;
        pop_d       = (burst_q != '0) && burst_wr_q;
        issue_pre   = 1'b0;
        issue_act   = 1'b0;
        try_access  = 1'b0;
        pt_set      = 1'b0;
        pt_clr      = 1'b0;
        pt_clr_all  = 1'b0;

        case (state_q)
            ST_WAIT_INIT: state_d = ST_ARB;   // init_done low is handled below
            ST_ARB: begin
                if (arb_any) begin
                    req_d       = arb_req;
                    grant_oh_d  = arb_grant;
                    grant_idx_d = arb_idx;
                    if (!open_valid_q[arb_req.bank]) begin
                        issue_act = 1'b1;
                    end else if (open_page_q[arb_req.bank] != ADDR_W'(arb_req.page)) begin
                        issue_pre = 1'b1;
                    end else begin
                        try_access = 1'b1;
                    end
                end
            end
            ST_PRE, ST_PRE_WAIT: begin
                if (wait_q == '0) begin
                    issue_act = 1'b1;
                end else begin
                    wait_d  = wait_q - CNT_W'(1);
                    state_d = ST_PRE_WAIT;
                end
            end
            ST_ACT, ST_ACT_WAIT: begin
                if (wait_q == '0) begin
                    try_access = 1'b1;
                end else begin
                    wait_d  = wait_q - CNT_W'(1);
                    state_d = ST_ACT_WAIT;
                end
            end
            ST_ACCESS: try_access = 1'b1;
            default:   state_d = ST_WAIT_INIT;
        endcase

        if (issue_pre) begin
            cs_d    = 1'b1;
            cmd_d   = CMD_PRE;
            bank_d  = BANK_W'(req_d.bank);
            pt_clr  = 1'b1;
            wait_d  = CNT_W'(T_RP - 1);
            state_d = ST_PRE;
        end

        if (issue_act) begin
            cs_d    = 1'b1;
            cmd_d   = CMD_ACT;
            bank_d  = BANK_W'(req_d.bank);
            addr_d  = ADDR_W'(req_d.page);
            pt_set  = 1'b1;
            wait_d  = CNT_W'(T_RCD - 1);
            state_d = ST_ACT;
        end

        // The bus is free next cycle once the running burst is on its last
        // beat, which keeps back-to-back accesses exactly BURST_SIZE apart.
        if (try_access) begin
            if (burst_q <= CNT_W'(1)) begin
                cs_d       = 1'b1;
                cmd_d      = req_d.write ? CMD_WR : CMD_RD;
                bank_d     = BANK_W'(req_d.bank);
                addr_d     = ADDR_W'(req_d.col);
                ready_d    = grant_oh_d;
                burst_d    = CNT_W'(BURST_SIZE);
                burst_wr_d = req_d.write;
                rr_ptr_d   = (grant_idx_d == IDX_W'(NUM_REQ - 1)) ? '0
                                                                    : grant_idx_d + IDX_W'(1);
                state_d    = ST_ARB;
            end else begin
                state_d    = ST_ACCESS;
            end
        end

        // Loss of DFI init aborts whatever is in progress; the DRAM state is
        // unknown afterwards, so every bank is treated as closed.
        if (!dfi__mmc__init_done) begin
            state_d     = ST_WAIT_INIT;
            req_d       = '0;
            grant_oh_d  = '0;
            grant_idx_d = '0;
            wait_d      = '0;
            burst_d     = '0;
            burst_wr_d  = 1'b0;
            cs_d        = 1'b0;
            cmd_d       = CMD_ACT;
            bank_d      = '0;
            addr_d      = '0;
            ready_d     = '0;
            pop_d       = 1'b0;
            pt_set      = 1'b0;
            pt_clr      = 1'b0;
            pt_clr_all  = 1'b1;
        end

        idle_d = (state_d == ST_ARB) && (burst_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            state_q     <= ST_WAIT_INIT;
            req_q       <= '0;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            wait_q      <= '0;
            burst_q     <= '0;
            burst_wr_q  <= 1'b0;
            cs_q        <= 1'b0;
            cmd_q       <= CMD_ACT;
            bank_q      <= '0;
            addr_q      <= '0;
            ready_q     <= '0;
            pop_q       <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_q      <= wait_d;
            burst_q     <= burst_d;
            burst_wr_q  <= burst_wr_d;
            cs_q        <= cs_d;
            cmd_q       <= cmd_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            ready_q     <= ready_d;
            pop_q       <= pop_d;
            idle_q      <= idle_d;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            open_valid_q <= '0;
        end else if (pt_clr_all) begin
            open_valid_q <= '0;
        end else if (pt_set) begin
            open_valid_q[pt_bank] <= 1'b1;
        end else if (pt_clr) begin
            open_valid_q[pt_bank] <= 1'b0;
        end
    end

    // NOTE: the open-page array is not reset; an entry is only read when its
    // open_valid bit is set, and that bit is always written together with it.
    always_ff @(posedge clk) begin
        if (pt_set) begin
            open_page_q[pt_bank] <= pt_page;
        end
    end

    assign sched__req__ready = ready_q;
    assign sched__dfi__cs    = cs_q;
    assign sched__dfi__cmd1  = cmd_q[1];
    assign sched__dfi__cmd0  = cmd_q[0];
    assign sched__dfi__bank  = bank_q;
    assign sched__dfi__addr  = addr_q;
    assign sched__wdata__pop = pop_q;
    assign sched__idle       = idle_q;

endmodule
